// File: rtl/divider_arbiter_pkg.sv
// Shared types and defaults for the round-robin divider arbiter.
package divider_arbiter_pkg;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;
endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_picker
  import divider_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    win_o = '0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one shift-subtract divider among NUM_REQ requesters.
// Define DIV_ARB_TIMEOUT_EN to add a WAIT-state watchdog that flushes a hung divider.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic [WIDTH-1:0]         rsp_remainder,
  output logic                     rsp_error,
  output logic                     busy,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  output logic                     div_flush,
  input  logic                     div_done,
  input  logic                     div_error,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e                     state_q;
  logic [IDX_W-1:0]               ptr_q, ptr_d, own_q, pick_idx;
  logic [NUM_REQ-1:0]             pick_win, gnt_q, ack_q;
  logic [WIDTH-1:0]               dvd_q, dvs_q, quot_q, rem_q;
  logic                           err_q, start_q, flush_q, wd_expire;
  logic [NUM_REQ-1:0][WIDTH-1:0]  dvd_v, dvs_v;

  assign dvd_v = req_dividend;
  assign dvs_v = req_divisor;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .idx_o (pick_idx)
  );

  assign ptr_d = (own_q == IDX_W'(NUM_REQ-1)) ? '0 : own_q + IDX_W'(1);

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [CNT_W-1:0] wd_cnt_q;
  // Counter holds the number of WAIT cycles already spent; expiry on the last allowed one.
  assign wd_expire = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES-1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      flush_q <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
      wd_cnt_q <= '0;
`endif
    end else begin
      ack_q   <= '0;
      start_q <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (|req) begin
          own_q   <= pick_idx;
          gnt_q   <= pick_win;
          dvd_q   <= dvd_v[pick_idx];
          dvs_q   <= dvs_v[pick_idx];
          start_q <= 1'b1;
          state_q <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
`ifdef DIV_ARB_TIMEOUT_EN
          wd_cnt_q <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the expiry cycle still yields a normal response.
          if (div_done) begin
            quot_q  <= div_quotient;
            rem_q   <= div_remainder;
            err_q   <= div_error;
            ack_q   <= gnt_q;
            state_q <= ST_RESPOND;
          end else if (wd_expire) begin
            quot_q  <= '1;
            rem_q   <= '1;
            err_q   <= 1'b1;
            ack_q   <= gnt_q;
            flush_q <= 1'b1;
            state_q <= ST_RESPOND;
          end
`ifdef DIV_ARB_TIMEOUT_EN
          else wd_cnt_q <= wd_cnt_q + CNT_W'(1);
`endif
        end
        ST_RESPOND: begin
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign ack           = ack_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_error     = err_q;
  assign busy          = (state_q != ST_IDLE);
  assign div_start     = start_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign div_flush     = flush_q;
endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: behavioural divider stub, transaction-level model, directed tests.
module tb_divider_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int NEVER = 1 << 30;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_dividend, req_divisor;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   rsp_quotient, rsp_remainder;
  logic           rsp_error, busy, div_start, div_flush;
  logic [W-1:0]   div_dividend, div_divisor;
  logic           div_done, div_error;
  logic [W-1:0]   div_quotient, div_remainder;

  divider_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .ack(ack),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_error(rsp_error),
    .busy(busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_flush(div_flush),
    .div_done(div_done), .div_error(div_error),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divider stand-in: done raised stub_lat edges after the start edge, held until next start.
  int stub_lat  = 6;
  bit stub_hang = 1'b0;
  int s_cnt;
  always @(posedge clk) begin
    if (reset || div_flush) begin
      div_done <= 1'b0; div_error <= 1'b0; div_quotient <= '0; div_remainder <= '0; s_cnt <= 0;
    end else if (div_start) begin
      div_done <= 1'b0;
      s_cnt    <= stub_lat;
      if (div_divisor == 0) begin
        div_quotient <= '1; div_remainder <= div_dividend; div_error <= 1'b1;
      end else begin
        div_quotient <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
        div_error <= 1'b0;
      end
    end else if (s_cnt > 0 && !stub_hang) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) div_done <= 1'b1;
    end
  end

  // Transaction model: one service at a time, winner by pointer rule, response at a computed cycle.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  int       cyc = 0;
  bit       m_busy = 1'b0, m_prev_idle = 1'b1, m_tmo = 1'b0;
  int       m_w = 0, m_n = 0, m_resp = 0, m_ptr = 0;
  int       m_a = 0, m_b = 0;
  int       m_q = 0, m_r = 0, m_e = 0;
  int       ack_log[$];

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      m_busy = 1'b0; m_prev_idle = 1'b1; m_ptr = 0; m_q = 0; m_r = 0; m_e = 0;
      chk("rst_gnt", gnt, 0);
      chk("rst_ack", ack, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_flush", div_flush, 0);
      chk("rst_rsp_q", rsp_quotient, 0);
      chk("rst_rsp_r", rsp_remainder, 0);
      chk("rst_rsp_e", rsp_error, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
    end else begin
      bit was_busy;
      if (!m_busy && m_prev_idle && req != 0) begin
        m_busy = 1'b1;
        m_w = pick(req, m_ptr);
        m_n = cyc;
        m_a = int'(req_dividend[m_w*W +: W]);
        m_b = int'(req_divisor[m_w*W +: W]);
`ifdef DIV_ARB_TIMEOUT_EN
        // Done is seen in WAIT cycle stub_lat+1; the watchdog allows TO WAIT cycles.
        m_tmo = stub_hang || (stub_lat + 1 > TO);
`else
        m_tmo = 1'b0;
`endif
        m_resp = m_tmo ? m_n + 1 + TO : (stub_hang ? NEVER : m_n + stub_lat + 2);
      end
      if (m_busy && cyc == m_resp) begin
        if (m_tmo)        begin m_q = 255; m_r = 255; m_e = 1; end
        else if (m_b == 0) begin m_q = 255; m_r = m_a; m_e = 1; end
        else              begin m_q = m_a / m_b; m_r = m_a % m_b; m_e = 0; end
      end
      chk("gnt", gnt, m_busy ? (1 << m_w) : 0);
      chk("ack", ack, (m_busy && cyc == m_resp) ? (1 << m_w) : 0);
      chk("div_start", div_start, (m_busy && cyc == m_n) ? 1 : 0);
      chk("busy", busy, m_busy ? 1 : 0);
      chk("div_flush", div_flush, (m_busy && cyc == m_resp && m_tmo) ? 1 : 0);
      chk("rsp_quotient", rsp_quotient, m_q);
      chk("rsp_remainder", rsp_remainder, m_r);
      chk("rsp_error", rsp_error, m_e);
      if (m_busy && cyc < m_resp) begin
        chk("div_dividend", div_dividend, m_a);
        chk("div_divisor", div_divisor, m_b);
      end
      was_busy = m_busy;
      if (m_busy && cyc == m_resp) begin
        ack_log.push_back(m_w);
        m_busy = 1'b0;
        m_ptr  = (m_w + 1) % N;
      end
      m_prev_idle = !was_busy;
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic wait_gnt(input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (gnt == 0 && k < budget) begin @(negedge clk); k++; end
    n_chk++;
    if (gnt == 0) begin n_fail++; $display("FAIL %s: no gnt within %0d cycles", name, budget); end
  endtask

  task automatic wait_ack(input int budget, input string name);
    int k = 0;
    @(negedge clk);
    while (ack == 0 && k < budget) begin @(negedge clk); k++; end
    n_chk++;
    if (ack == 0) begin n_fail++; $display("FAIL %s: no ack within %0d cycles", name, budget); end
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL global_timeout: bench did not complete, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    int n_before;
    reset = 1'b1; req = '1; req_dividend = '0; req_divisor = '0;

    // Reset held two edges with every request raised.
    repeat (2) @(negedge clk);
    chk("t1_gnt", gnt, 0);
    chk("t1_ack", ack, 0);
    chk("t1_div_start", div_start, 0);
    chk("t1_busy", busy, 0);
    chk("t1_div_flush", div_flush, 0);
    reset = 1'b0; req = '0;

    // Plain divide; request dropped and operand changed mid-operation.
    @(negedge clk);
    set_op(0, 100, 7); req = 4'b0001;
    wait_gnt(5, "t2_gnt");
    chk("t2_gnt_val", gnt, 4'b0001);
    req = '0; set_op(0, 55, 3);
    wait_ack(40, "t2_ack_wait");
    chk("t2_ack", ack, 4'b0001);
    chk("t2_q", rsp_quotient, 14);
    chk("t2_r", rsp_remainder, 2);
    chk("t2_e", rsp_error, 0);

    // Divide by zero.
    @(negedge clk);
    set_op(2, 9, 0); req = 4'b0100;
    wait_ack(40, "t3_ack_wait");
    chk("t3_ack", ack, 4'b0100);
    chk("t3_e", rsp_error, 1);
    req = '0;
    @(negedge clk);
    chk("t3_busy_idle", busy, 0);
    chk("t3_q_hold", rsp_quotient, 8'hFF);

    // Reset during WAIT of requester 1.
    stub_lat = 10;
    set_op(1, 50, 5); req = 4'b0010;
    wait_gnt(5, "t5_gnt");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_gnt", gnt, 0);
    reset = 1'b0; req = '0;
    n_before = ack_log.size();
    repeat (15) @(negedge clk);
    chk("t5_noack", ack_log.size(), n_before);

    // All requesters held: pointer restarts at 0 after reset and rotates with wrap.
    stub_lat = 4;
    ack_log.delete();
    for (int i = 0; i < N; i++) set_op(i, 8'(20 + 10*i), 8'(i + 1));
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(30, "t4_ack_wait");
      chk("t4_ack_order", ack, 1 << order[i]);
      if (i == 2) begin
        chk("t4_q2", rsp_quotient, 13);
        chk("t4_r2", rsp_remainder, 1);
      end
    end
    req = '0;
    chk("t4_log_len", ack_log.size(), 5);
    for (int i = 0; i < 4; i++) chk("t4_log", ack_log[i], i);
    repeat (3) @(negedge clk);

`ifdef DIV_ARB_TIMEOUT_EN
    // done on the expiry cycle wins.
    stub_lat = TO - 1;
    set_op(0, 77, 8); req = 4'b0001;
    wait_ack(60, "t6a_ack_wait");
    chk("t6a_e", rsp_error, 0);
    chk("t6a_q", rsp_quotient, 9);
    chk("t6a_r", rsp_remainder, 5);
    chk("t6a_flush", div_flush, 0);
    req = '0;
    repeat (2) @(negedge clk);
    // Hung divider: watchdog response after TO WAIT cycles.
    stub_hang = 1'b1;
    set_op(0, 40, 3); req = 4'b0001;
    wait_ack(60, "t6b_ack_wait");
    chk("t6b_ack", ack, 4'b0001);
    chk("t6b_e", rsp_error, 1);
    chk("t6b_q", rsp_quotient, 8'hFF);
    chk("t6b_r", rsp_remainder, 8'hFF);
    chk("t6b_flush", div_flush, 1);
    req = '0;
    @(negedge clk);
    stub_hang = 1'b0;
    chk("t6b_flush_pulse", div_flush, 0);
`else
    // Hung divider without watchdog: waits forever.
    stub_hang = 1'b1;
    n_before = ack_log.size();
    set_op(0, 40, 3); req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (200) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_noack", ack_log.size(), n_before);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; stub_hang = 1'b0;
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
